// File: rtl/sdram_cmd_sequencer.sv
// Registered SDRAM command issuer: abstract 4-bit commands in, timed control pins out.
// Enforces tRCD/tRP/tRFC/tMRD/tWR with a wait counter and tracks per-bank open rows.
module sdram_cmd_sequencer #(
  parameter int BA_W  = 2,
  parameter int ROW_W = 12,
  parameter int COL_W = 8,
  parameter int T_RCD = 3,
  parameter int T_RP  = 3,
  parameter int T_RFC = 7,
  parameter int T_MRD = 2,
  parameter int T_WR  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [3:0]                  cmd,
  input  logic [BA_W+ROW_W+COL_W-1:0] cmd_addr,
  input  logic [ROW_W-1:0]            cmd_mrs,
  output logic                        err,
  output logic [(1<<BA_W)-1:0]        bank_open,
  output logic                        cke,
  output logic                        cs_n,
  output logic                        ras_n,
  output logic                        cas_n,
  output logic                        we_n,
  output logic [BA_W-1:0]             ba,
  output logic [ROW_W-1:0]            addr
);

  localparam int NBANK = 1 << BA_W;
  localparam int N_SUM = T_RCD + T_RP + T_RFC + T_MRD + T_WR;
  localparam int CNT_W = $clog2(N_SUM + 1);

  localparam logic [CNT_W-1:0] N_ACT = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] N_RP  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] N_WRA = CNT_W'(T_WR + T_RP - 1);
  localparam logic [CNT_W-1:0] N_RFC = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] N_MRD = CNT_W'(T_MRD - 1);

  localparam logic [3:0] C_DESL  = 4'h0;
  localparam logic [3:0] C_NOP   = 4'h1;
  localparam logic [3:0] C_MRS   = 4'h2;
  localparam logic [3:0] C_ACT   = 4'h3;
  localparam logic [3:0] C_READ  = 4'h4;
  localparam logic [3:0] C_READA = 4'h5;
  localparam logic [3:0] C_WRIT  = 4'h6;
  localparam logic [3:0] C_WRITA = 4'h7;
  localparam logic [3:0] C_PRE   = 4'h8;
  localparam logic [3:0] C_PALL  = 4'h9;
  localparam logic [3:0] C_BST   = 4'hA;
  localparam logic [3:0] C_REF   = 4'hB;
  localparam logic [3:0] C_SELF  = 4'hC;
  localparam logic [3:0] C_SUP   = 4'hD;
  localparam logic [3:0] C_REC   = 4'hE;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SLEEP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sleep_self_q, sleep_self_d;
  logic [NBANK-1:0]   bank_open_q, bank_open_d;
  logic               err_q, err_d;
  logic               cke_q, cke_d;
  logic               cs_n_q, cs_n_d;
  logic               ras_n_q, ras_n_d;
  logic               cas_n_q, cas_n_d;
  logic               we_n_q, we_n_d;
  logic [BA_W-1:0]    ba_q, ba_d;
  logic [ROW_W-1:0]   addr_q, addr_d;

  logic [BA_W-1:0]    in_ba;
  logic [ROW_W-1:0]   in_row;
  logic [COL_W-1:0]   in_col;
  logic [NBANK-1:0]   bank_hit;
  logic               accept;
  logic               tgt_open;
  logic               any_open;
  logic [ROW_W-1:0]   col_addr;
  logic [CNT_W-1:0]   wait_n;

  assign in_ba  = cmd_addr[BA_W+ROW_W+COL_W-1 -: BA_W];
  assign in_row = cmd_addr[ROW_W+COL_W-1 -: ROW_W];
  assign in_col = cmd_addr[COL_W-1:0];

  for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank_hit
    assign bank_hit[gi] = (in_ba == BA_W'(gi));
  end

  assign cmd_ready = (state_q != ST_WAIT);
  assign accept    = cmd_valid && cmd_ready;
  assign tgt_open  = |(bank_open_q & bank_hit);
  assign any_open  = |bank_open_q;

  always_comb begin
    col_addr              = '0;
    col_addr[COL_W-1:0]   = in_col;
    col_addr[10]          = cmd[0];  // auto-precharge variants have the low code bit set
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sleep_self_d = sleep_self_q;
    bank_open_d  = bank_open_q;
    err_d        = 1'b0;
    wait_n       = '0;
    cke_d        = 1'b1;
    cs_n_d       = 1'b0;
    ras_n_d      = 1'b1;
    cas_n_d      = 1'b1;
    we_n_d       = 1'b1;
    ba_d         = '0;
    addr_d       = '0;

    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_SLEEP: begin
        // Pins keep their entry values (cke low) unless a legal exit is accepted.
        cke_d   = cke_q;
        cs_n_d  = cs_n_q;
        ras_n_d = ras_n_q;
        cas_n_d = cas_n_q;
        we_n_d  = we_n_q;
        ba_d    = ba_q;
        addr_d  = addr_q;
        if (accept) begin
          if (cmd == C_NOP || cmd == C_REC) begin
            cke_d   = 1'b1;
            cs_n_d  = 1'b0;
            ras_n_d = 1'b1;
            cas_n_d = 1'b1;
            we_n_d  = 1'b1;
            ba_d    = '0;
            addr_d  = '0;
            if (sleep_self_q && N_RFC != '0) begin
              state_d = ST_WAIT;
              cnt_d   = N_RFC;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      default: begin
        if (accept) begin
          case (cmd)
            C_DESL: cs_n_d = 1'b1;
            C_NOP:  ;
            C_MRS: begin
              if (any_open) err_d = 1'b1;
              else begin
                ras_n_d = 1'b0;
                cas_n_d = 1'b0;
                we_n_d  = 1'b0;
                addr_d  = cmd_mrs;
                wait_n  = N_MRD;
              end
            end
            C_ACT: begin
              if (tgt_open) err_d = 1'b1;
              else begin
                ras_n_d     = 1'b0;
                ba_d        = in_ba;
                addr_d      = in_row;
                bank_open_d = bank_open_q | bank_hit;
                wait_n      = N_ACT;
              end
            end
            C_READ, C_READA, C_WRIT, C_WRITA: begin
              if (!tgt_open) err_d = 1'b1;
              else begin
                // The bank address travels with column commands so the device knows the target.
                cas_n_d = 1'b0;
                we_n_d  = ~cmd[1];
                ba_d    = in_ba;
                addr_d  = col_addr;
                if (cmd[0]) bank_open_d = bank_open_q & ~bank_hit;
                if (cmd == C_READA) wait_n = N_RP;
                if (cmd == C_WRITA) wait_n = N_WRA;
              end
            end
            C_PRE: begin
              ras_n_d     = 1'b0;
              we_n_d      = 1'b0;
              ba_d        = in_ba;
              bank_open_d = bank_open_q & ~bank_hit;
              wait_n      = N_RP;
            end
            C_PALL: begin
              ras_n_d      = 1'b0;
              we_n_d       = 1'b0;
              addr_d[10]   = 1'b1;
              bank_open_d  = '0;
              wait_n       = N_RP;
            end
            C_BST: we_n_d = 1'b0;
            C_REF: begin
              if (any_open) err_d = 1'b1;
              else begin
                ras_n_d = 1'b0;
                cas_n_d = 1'b0;
                wait_n  = N_RFC;
              end
            end
            C_SELF: begin
              if (any_open) err_d = 1'b1;
              else begin
                cke_d        = 1'b0;
                ras_n_d      = 1'b0;
                cas_n_d      = 1'b0;
                state_d      = ST_SLEEP;
                sleep_self_d = 1'b1;
              end
            end
            C_SUP: begin
              cke_d        = 1'b0;
              state_d      = ST_SLEEP;
              sleep_self_d = 1'b0;
            end
            default: err_d = 1'b1;  // REC outside SLEEP, and the illegal code
          endcase
          if (wait_n != '0) begin
            state_d = ST_WAIT;
            cnt_d   = wait_n;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sleep_self_q <= 1'b0;
      bank_open_q  <= '0;
      err_q        <= 1'b0;
      cke_q        <= 1'b1;
      cs_n_q       <= 1'b1;
      ras_n_q      <= 1'b1;
      cas_n_q      <= 1'b1;
      we_n_q       <= 1'b1;
      ba_q         <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sleep_self_q <= sleep_self_d;
      bank_open_q  <= bank_open_d;
      err_q        <= err_d;
      cke_q        <= cke_d;
      cs_n_q       <= cs_n_d;
      ras_n_q      <= ras_n_d;
      cas_n_q      <= cas_n_d;
      we_n_q       <= we_n_d;
      ba_q         <= ba_d;
      addr_q       <= addr_d;
    end
  end

  assign err       = err_q;
  assign bank_open = bank_open_q;
  assign cke       = cke_q;
  assign cs_n      = cs_n_q;
  assign ras_n     = ras_n_q;
  assign cas_n     = cas_n_q;
  assign we_n      = we_n_q;
  assign ba        = ba_q;
  assign addr      = addr_q;

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Bench for sdram_cmd_sequencer: directed scenarios plus random traffic, all checked
// against a command-level reference model of the sequencer.
module tb_sdram_cmd_sequencer;

  localparam int BA_W  = 2;
  localparam int ROW_W = 12;
  localparam int COL_W = 8;
  localparam int T_RCD = 3;
  localparam int T_RP  = 3;
  localparam int T_RFC = 7;
  localparam int T_MRD = 2;
  localparam int T_WR  = 2;
  localparam int NBANK = 1 << BA_W;
  localparam int AW    = BA_W + ROW_W + COL_W;
  localparam int OW    = 2 + NBANK + 5 + BA_W + ROW_W;

  localparam int C_DESL = 0,  C_NOP = 1,   C_MRS = 2,  C_ACT = 3;
  localparam int C_READ = 4,  C_READA = 5, C_WRIT = 6, C_WRITA = 7;
  localparam int C_PRE = 8,   C_PALL = 9,  C_BST = 10, C_REF = 11;
  localparam int C_SELF = 12, C_SUP = 13,  C_REC = 14;

  localparam int M_IDLE = 0, M_WAIT = 1, M_SLEEP = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd;
  logic [AW-1:0]     cmd_addr;
  logic [ROW_W-1:0]  cmd_mrs;
  logic              err;
  logic [NBANK-1:0]  bank_open;
  logic              cke, cs_n, ras_n, cas_n, we_n;
  logic [BA_W-1:0]   ba;
  logic [ROW_W-1:0]  addr;

  sdram_cmd_sequencer #(
    .BA_W(BA_W), .ROW_W(ROW_W), .COL_W(COL_W), .T_RCD(T_RCD), .T_RP(T_RP),
    .T_RFC(T_RFC), .T_MRD(T_MRD), .T_WR(T_WR)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .cmd_addr(cmd_addr), .cmd_mrs(cmd_mrs), .err(err), .bank_open(bank_open),
    .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr)
  );

  always #5 clk = ~clk;

  logic [OW-1:0] obs;
  assign obs = {cmd_ready, err, bank_open, cke, cs_n, ras_n, cas_n, we_n, ba, addr};

  int vectors = 0;
  int miscompares = 0;

  // Reference model: sequencer mode, remaining wait cycles, open banks, expected pins.
  int               m_mode;
  int               m_wait;
  bit               m_sleep_self;
  logic [NBANK-1:0] m_banks;
  logic             e_err, e_cke;
  logic [3:0]       e_pin;
  logic [BA_W-1:0]  e_ba;
  logic [ROW_W-1:0] e_addr;
  logic [OW-1:0]    exp_vec;

  function automatic logic [3:0] pin_code(int c);
    case (c)
      C_DESL:                 return 4'b1111;
      C_MRS:                  return 4'b0000;
      C_ACT:                  return 4'b0011;
      C_READ, C_READA:        return 4'b0101;
      C_WRIT, C_WRITA:        return 4'b0100;
      C_PRE, C_PALL:          return 4'b0010;
      C_BST:                  return 4'b0110;
      C_REF, C_SELF:          return 4'b0001;
      default:                return 4'b0111;
    endcase
  endfunction

  function automatic int wait_len(int c);
    case (c)
      C_ACT:                  return T_RCD - 1;
      C_PRE, C_PALL, C_READA: return T_RP - 1;
      C_WRITA:                return T_WR + T_RP - 1;
      C_REF:                  return T_RFC - 1;
      C_MRS:                  return T_MRD - 1;
      default:                return 0;
    endcase
  endfunction

  function automatic bit is_rejected(int c, bit tgt_open, bit any_open);
    case (c)
      C_ACT:                           return tgt_open;
      C_READ, C_READA, C_WRIT, C_WRITA: return !tgt_open;
      C_MRS, C_REF, C_SELF:            return any_open;
      C_REC, 15:                       return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic [ROW_W-1:0] addr_for(int c, logic [ROW_W-1:0] r,
                                                logic [COL_W-1:0] col, logic [ROW_W-1:0] mrs);
    int a;
    a = 0;
    case (c)
      C_MRS:           return mrs;
      C_ACT:           return r;
      C_READ, C_WRIT:  a = int'(col);
      C_READA, C_WRITA: a = int'(col) + 1024;
      C_PALL:          a = 1024;
      default:         a = 0;
    endcase
    return ROW_W'(a);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_wait = 0; m_sleep_self = 1'b0; m_banks = '0;
    e_err = 1'b0; e_cke = 1'b1; e_pin = 4'b1111; e_ba = '0; e_addr = '0;
    exp_vec = {1'b1, e_err, m_banks, e_cke, e_pin, e_ba, e_addr};
  endtask

  task automatic set_nop();
    e_cke = 1'b1; e_pin = 4'b0111; e_ba = '0; e_addr = '0;
  endtask

  task automatic model_step();
    logic [BA_W-1:0]  b;
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] col;
    bit               acc;
    int               c;
    int               n;
    b   = cmd_addr[AW-1 -: BA_W];
    r   = cmd_addr[ROW_W+COL_W-1 -: ROW_W];
    col = cmd_addr[COL_W-1:0];
    c   = int'(cmd);
    acc = cmd_valid && (m_mode != M_WAIT);
    e_err = 1'b0;
    if (m_mode == M_WAIT) begin
      set_nop();
      m_wait--;
      if (m_wait == 0) m_mode = M_IDLE;
    end else if (m_mode == M_SLEEP) begin
      if (acc && (c == C_NOP || c == C_REC)) begin
        set_nop();
        if (m_sleep_self && T_RFC - 1 > 0) begin
          m_mode = M_WAIT; m_wait = T_RFC - 1;
        end else m_mode = M_IDLE;
      end else if (acc) e_err = 1'b1;
    end else begin
      set_nop();
      if (acc) begin
        if (is_rejected(c, m_banks[b], m_banks != '0)) e_err = 1'b1;
        else begin
          e_cke  = !(c == C_SELF || c == C_SUP);
          e_pin  = pin_code(c);
          e_ba   = (c == C_ACT || c == C_PRE || (c >= C_READ && c <= C_WRITA)) ? b : '0;
          e_addr = addr_for(c, r, col, cmd_mrs);
          if (c == C_ACT) m_banks[b] = 1'b1;
          if (c == C_PRE || c == C_READA || c == C_WRITA) m_banks[b] = 1'b0;
          if (c == C_PALL) m_banks = '0;
          if (c == C_SELF || c == C_SUP) begin
            m_mode = M_SLEEP; m_sleep_self = (c == C_SELF);
          end else begin
            n = wait_len(c);
            if (n > 0) begin m_mode = M_WAIT; m_wait = n; end
          end
        end
      end
    end
    exp_vec = {m_mode != M_WAIT, e_err, m_banks, e_cke, e_pin, e_ba, e_addr};
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int c, logic [BA_W-1:0] b, logic [ROW_W-1:0] r, logic [COL_W-1:0] col);
    cmd_valid = 1'b1;
    cmd       = 4'(c);
    cmd_addr  = {b, r, col};
  endtask

  task automatic idle_in();
    cmd_valid = 1'b0;
    cmd       = 4'($urandom_range(0, 15));
    cmd_addr  = AW'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd = '0; cmd_addr = '0; cmd_mrs = '0;
    #2;
    model_reset();
    vectors++;
    if (obs !== {1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 2'd0, 12'h000}) begin
      miscompares++; $display("FAIL reset_state: got %h required %h", obs, {1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 2'd0, 12'h000});
    end
    #10;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_act_reada();
    int low;
    do_reset();
    drive(C_ACT, 2'd1, 12'h123, 8'h00);
    tick();
    idle_in();
    vectors++;
    if ({cs_n, ras_n, cas_n, we_n, ba, addr} !== {4'b0011, 2'd1, 12'h123}) begin
      miscompares++; $display("FAIL act_pins: got %b/%0d/%h required 0011/1/123", {cs_n, ras_n, cas_n, we_n}, ba, addr);
    end
    vectors++;
    if (bank_open !== 4'b0010) begin
      miscompares++; $display("FAIL act_bank_open: got %b required 0010", bank_open);
    end
    low = 0;
    while (cmd_ready === 1'b0 && low < 20) begin
      low++;
      tick();
      vectors++;
      if (obs !== exp_vec) begin miscompares++; $display("FAIL act_wait_model: got %h required %h", obs, exp_vec); end
    end
    vectors++;
    if (low != T_RCD - 1) begin miscompares++; $display("FAIL act_ready_low: got %0d cycles required %0d", low, T_RCD - 1); end

    drive(C_READA, 2'd1, 12'h000, 8'h45);
    tick();
    idle_in();
    vectors++;
    if ({cs_n, ras_n, cas_n, we_n, addr} !== {4'b0101, 12'h445} || bank_open !== 4'b0000) begin
      miscompares++; $display("FAIL reada_pins: got %b/%h bank %b required 0101/445 bank 0000", {cs_n, ras_n, cas_n, we_n}, addr, bank_open);
    end
    vectors++;
    if (obs !== exp_vec) begin miscompares++; $display("FAIL reada_model: got %h required %h", obs, exp_vec); end
    low = 0;
    while (cmd_ready === 1'b0 && low < 20) begin low++; tick(); end
    vectors++;
    if (low != T_RP - 1) begin miscompares++; $display("FAIL reada_ready_low: got %0d cycles required %0d", low, T_RP - 1); end
  endtask

  task automatic test_reject();
    drive(C_READ, 2'd2, 12'h000, 8'h10);
    tick();
    idle_in();
    vectors++;
    if ({err, cmd_ready, cs_n, ras_n, cas_n, we_n, bank_open} !== {1'b1, 1'b1, 4'b0111, 4'b0000}) begin
      miscompares++; $display("FAIL reject_read: err %b ready %b pins %b bank %b required 1 1 0111 0000", err, cmd_ready, {cs_n, ras_n, cas_n, we_n}, bank_open);
    end
    tick();
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL reject_err_pulse: got %b required 0", err); end
  endtask

  task automatic test_mrs();
    int low;
    drive(C_MRS, 2'd3, 12'hFFF, 8'hFF);
    cmd_mrs = 12'h032;
    tick();
    idle_in();
    vectors++;
    if ({cs_n, ras_n, cas_n, we_n, ba, addr, cmd_ready} !== {4'b0000, 2'd0, 12'h032, 1'b0}) begin
      miscompares++; $display("FAIL mrs_pins: got %b/%0d/%h ready %b required 0000/0/032 ready 0", {cs_n, ras_n, cas_n, we_n}, ba, addr, cmd_ready);
    end
    low = 0;
    while (cmd_ready === 1'b0 && low < 20) begin low++; tick(); end
    vectors++;
    if (low != T_MRD - 1) begin miscompares++; $display("FAIL mrs_ready_low: got %0d required %0d", low, T_MRD - 1); end
    drive(C_ACT, 2'd0, 12'h055, 8'h00);
    tick();
    idle_in();
    while (cmd_ready === 1'b0 && low < 40) begin low++; tick(); end
    drive(C_MRS, 2'd0, 12'h000, 8'h00);
    tick();
    idle_in();
    vectors++;
    if (err !== 1'b1 || bank_open !== 4'b0001 || obs !== exp_vec) begin
      miscompares++; $display("FAIL mrs_open_reject: err %b bank %b obs %h required err 1 bank 0001 obs %h", err, bank_open, obs, exp_vec);
    end
  endtask

  task automatic test_sleep();
    int low;
    drive(C_PALL, 2'd0, 12'h000, 8'h00);
    tick();
    idle_in();
    vectors++;
    if (addr !== 12'h400 || bank_open !== 4'b0000 || obs !== exp_vec) begin
      miscompares++; $display("FAIL pall: addr %h bank %b required 400 0000", addr, bank_open);
    end
    low = 0;
    while (cmd_ready === 1'b0 && low < 20) begin low++; tick(); end
    drive(C_SELF, 2'd0, 12'h000, 8'h00);
    tick();
    idle_in();
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (cke !== 1'b0 || {cs_n, ras_n, cas_n, we_n} !== 4'b0001 || obs !== exp_vec) begin
        miscompares++; $display("FAIL self_hold cyc %0d: cke %b pins %b required 0 0001", i, cke, {cs_n, ras_n, cas_n, we_n});
      end
      tick();
    end
    drive(C_WRIT, 2'd0, 12'h000, 8'h01);
    tick();
    idle_in();
    vectors++;
    if (err !== 1'b1 || cke !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL sleep_writ_reject: err %b cke %b ready %b required 1 0 1", err, cke, cmd_ready);
    end
    drive(C_REC, 2'd0, 12'h000, 8'h00);
    tick();
    idle_in();
    vectors++;
    if ({cke, cs_n, ras_n, cas_n, we_n} !== 5'b10111 || obs !== exp_vec) begin
      miscompares++; $display("FAIL rec_exit: got %b required 10111", {cke, cs_n, ras_n, cas_n, we_n});
    end
    low = 0;
    while (cmd_ready === 1'b0 && low < 20) begin low++; tick(); end
    vectors++;
    if (low != T_RFC - 1) begin miscompares++; $display("FAIL rec_ready_low: got %0d required %0d", low, T_RFC - 1); end
  endtask

  task automatic test_reset_mid_wait();
    drive(C_REF, 2'd0, 12'h000, 8'h00);
    tick();
    idle_in();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (obs !== {1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 2'd0, 12'h000}) begin
      miscompares++; $display("FAIL reset_mid_wait: got %h required %h", obs, {1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 2'd0, 12'h000});
    end
    #3;
    rst = 1'b0;
    model_reset();
    drive(C_ACT, 2'd3, 12'hABC, 8'h00);
    tick();
    idle_in();
    vectors++;
    if ({cs_n, ras_n, cas_n, we_n, ba, addr, bank_open} !== {4'b0011, 2'd3, 12'hABC, 4'b1000}) begin
      miscompares++; $display("FAIL act_after_reset: got %b/%0d/%h bank %b required 0011/3/abc bank 1000", {cs_n, ras_n, cas_n, we_n}, ba, addr, bank_open);
    end
  endtask

  task automatic test_back_to_back();
    int codes[4] = '{C_NOP, C_DESL, C_BST, C_NOP};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(codes[i % 4], 2'($urandom), 12'($urandom), 8'($urandom));
      tick();
      vectors++;
      if (cmd_ready !== 1'b1 || {cs_n, ras_n, cas_n, we_n} !== pin_code(codes[i % 4]) || obs !== exp_vec) begin
        miscompares++; $display("FAIL back_to_back %0d: ready %b pins %b required 1 %b", i, cmd_ready, {cs_n, ras_n, cas_n, we_n}, pin_code(codes[i % 4]));
      end
    end
    idle_in();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = ($urandom_range(0, 9) < 7);
      cmd       = 4'($urandom_range(0, 15));
      cmd_addr  = AW'($urandom);
      cmd_mrs   = ROW_W'($urandom);
      tick();
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++; $display("FAIL random cyc %0d cmd %0d: got %h required %h", i, cmd, obs, exp_vec);
      end
    end
    idle_in();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_act_reada();
    test_reject();
    test_mrs();
    test_sleep();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
